// File: rtl/ball_fsm.sv
// Ball controller for the 160x120 paddle game: one-pixel ball stepped diagonally,
// drawn as a white/black colour pair for the shared VGA plot path.
module ball_fsm #(
    parameter int MOVE_CYCLES  = 1000000,
    parameter int ERASE_CYCLES = 40002,
    parameter int START_X      = 80,
    parameter int START_Y      = 60,
    parameter int X_MAX        = 159,
    parameter int PADDLE_Y     = 116,
    parameter int PADDLE_W     = 16,
    parameter int Y_LOSE       = 118
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] paddle_X,
    output logic [7:0] ballX,
    output logic [6:0] ballY,
    output logic [2:0] colour,
    output logic       gameOver
);

    localparam int CMAX = (MOVE_CYCLES > ERASE_CYCLES) ? MOVE_CYCLES : ERASE_CYCLES;
    localparam int TWC  = $clog2(CMAX + 1);
    localparam int TW   = (TWC < 20) ? 20 : TWC;

    localparam logic [TW-1:0] MOVE_LAST  = TW'(MOVE_CYCLES - 1);
    localparam logic [TW-1:0] ERASE_LAST = TW'(ERASE_CYCLES - 1);
    localparam logic [7:0]    X_START    = 8'(START_X);
    localparam logic [6:0]    Y_START    = 7'(START_Y);
    localparam logic [7:0]    X_EDGE     = 8'(X_MAX);
    localparam logic [6:0]    Y_HIT      = 7'(PADDLE_Y - 1);
    localparam logic [6:0]    Y_END      = 7'(Y_LOSE);
    localparam logic [8:0]    PAD_SPAN   = 9'(PADDLE_W - 1);
    localparam logic [2:0]    WHITE      = 3'b111;
    localparam logic [2:0]    BLACK      = 3'b000;

    typedef enum logic [1:0] {IDLE, DRAW, ERASE, OVER} state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic          dx_left;   // 1: moving towards x=0
    logic          dy_up;     // 1: moving towards y=0

    logic          nx_left;
    logic          nx_up;
    logic          hit;
    logic [7:0]    nx_x;
    logic [6:0]    nx_y;
    logic [8:0]    x9;
    logic [8:0]    pad_lo;
    logic [8:0]    pad_hi;

    // Next direction and position from the current ones; walls and paddle can
    // reflect both axes in the same step.
    always_comb begin
        x9     = {1'b0, ballX};
        pad_lo = {1'b0, paddle_X};
        pad_hi = pad_lo + PAD_SPAN;
        hit    = !dy_up && (ballY == Y_HIT) && (x9 >= pad_lo) && (x9 <= pad_hi);

        nx_left = dx_left;
        if (!dx_left && ballX == X_EDGE)
            nx_left = 1'b1;
        else if (dx_left && ballX == 8'd0)
            nx_left = 1'b0;
        nx_x = nx_left ? ballX - 8'd1 : ballX + 8'd1;

        nx_up = dy_up;
        if (dy_up && ballY == 7'd0)
            nx_up = 1'b0;
        else if (hit)
            nx_up = 1'b1;
        nx_y = nx_up ? ballY - 7'd1 : ballY + 7'd1;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state    <= IDLE;
            timer    <= '0;
            ballX    <= X_START;
            ballY    <= Y_START;
            colour   <= WHITE;
            gameOver <= 1'b0;
            dx_left  <= 1'b0;
            dy_up    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    colour <= WHITE;
                    if (!start) begin
                        timer <= '0;
                        state <= DRAW;
                    end
                end
                DRAW: begin
                    if (timer == MOVE_LAST) begin
                        timer  <= '0;
                        colour <= BLACK;
                        state  <= ERASE;
                    end else begin
                        timer  <= timer + TW'(1);
                        colour <= WHITE;
                    end
                end
                ERASE: begin
                    if (timer == ERASE_LAST) begin
                        dx_left <= nx_left;
                        dy_up   <= nx_up;
                        ballX   <= nx_x;
                        ballY   <= nx_y;
                        colour  <= WHITE;
                        timer   <= '0;
                        if (nx_y == Y_END) begin
                            gameOver <= 1'b1;
                            state    <= OVER;
                        end else begin
                            state <= DRAW;
                        end
                    end else begin
                        timer  <= timer + TW'(1);
                        colour <= BLACK;
                    end
                end
                OVER: begin
                    gameOver <= 1'b1;
                    colour   <= WHITE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ball_fsm.sv
// Bench for ball_fsm: vector table, scripted trajectories on two start positions,
// then randomized play against a step-count reference model.
module tb_ball_fsm;

    localparam int M = 4;
    localparam int E = 3;
    localparam int P = M + E;

    logic       clock = 1'b0;
    always #5 clock = ~clock;

    logic       rs_a = 1'b0, st_a = 1'b1, rs_b = 1'b0, st_b = 1'b1;
    logic [7:0] px_a = 8'd0, px_b = 8'd0;
    logic [7:0] bx_a, bx_b;
    logic [6:0] by_a, by_b;
    logic [2:0] col_a, col_b;
    logic       go_a, go_b;

    ball_fsm #(.MOVE_CYCLES(M), .ERASE_CYCLES(E)) dut (
        .clock(clock), .resetn(rs_a), .start(st_a), .paddle_X(px_a),
        .ballX(bx_a), .ballY(by_a), .colour(col_a), .gameOver(go_a));

    ball_fsm #(.MOVE_CYCLES(M), .ERASE_CYCLES(E), .START_X(4), .START_Y(40)) dut_b (
        .clock(clock), .resetn(rs_b), .start(st_b), .paddle_X(px_b),
        .ballX(bx_b), .ballY(by_b), .colour(col_b), .gameOver(go_b));

    int checks = 0;
    int errors = 0;

    // ph: 0 waiting, 1 playing, 2 lost. n counts edges since the start edge;
    // every P-th edge moves the ball, the last E edges of each period are black.
    typedef struct {
        int ph, n, x, y, dx, dy;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mstep(mdl_t m, logic rs, logic st, int px, int sx, int sy);
        mdl_t r = m;
        int   ox;
        if (!rs) begin
            r.ph = 0; r.n = 0; r.x = sx; r.y = sy; r.dx = 1; r.dy = -1;
            return r;
        end
        if (r.ph == 0) begin
            if (!st) begin r.ph = 1; r.n = 0; end
        end else if (r.ph == 1) begin
            r.n++;
            if (r.n % P == 0) begin
                ox = r.x;
                if (r.dx == 1 && r.x == 159) r.dx = -1;
                else if (r.dx == -1 && r.x == 0) r.dx = 1;
                r.x += r.dx;
                if (r.dy == -1 && r.y == 0) r.dy = 1;
                else if (r.dy == 1 && r.y == 115 && ox >= px && ox <= px + 15) r.dy = -1;
                r.y += r.dy;
                if (r.y == 118) r.ph = 2;
            end
        end
        return r;
    endfunction

    function automatic logic [18:0] mexp(mdl_t m);
        int c = (m.ph == 1 && (m.n % P) >= M) ? 0 : 7;
        return {8'(m.x), 7'(m.y), 3'(c), (m.ph == 2)};
    endfunction

    task automatic cmp(string nm, logic [18:0] act, logic [18:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got x=%0d y=%0d c=%0d go=%0d, want x=%0d y=%0d c=%0d go=%0d",
                     nm, act[18:11], act[10:4], act[3:1], act[0],
                     exp[18:11], exp[10:4], exp[3:1], exp[0]);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        ma = mstep(ma, rs_a, st_a, int'(px_a), 80, 60);
        mb = mstep(mb, rs_b, st_b, int'(px_b), 4, 40);
        @(negedge clock);
        cmp("model_a", {bx_a, by_a, col_a, go_a}, mexp(ma));
        cmp("model_b", {bx_b, by_b, col_b, go_b}, mexp(mb));
    endtask

    task automatic steps(int k);
        repeat (k * P) tick();
    endtask

    task automatic exp_a(string nm, int x, int y, int c, int g);
        cmp(nm, {bx_a, by_a, col_a, go_a}, {8'(x), 7'(y), 3'(c), 1'(g)});
    endtask

    task automatic exp_b(string nm, int x, int y, int c, int g);
        cmp(nm, {bx_b, by_b, col_b, go_b}, {8'(x), 7'(y), 3'(c), 1'(g)});
    endtask

    typedef struct {
        logic rs, st;
        int   ex, ey, ec, eg;
    } vec_t;

    vec_t tbl[11];

    initial begin
        ma = '{0, 0, 0, 0, 1, -1};
        mb = ma;

        // Reset, then a long idle with start released.
        tick();
        exp_a("reset", 80, 60, 7, 0);
        exp_b("reset_b", 4, 40, 7, 0);
        rs_a = 1'b1;
        repeat (100) tick();
        exp_a("idle100", 80, 60, 7, 0);

        // Start pulse and one full draw/erase/move period.
        tbl[0]  = '{1'b0, 1'b1, 80, 60, 7, 0};
        tbl[1]  = '{1'b1, 1'b1, 80, 60, 7, 0};
        tbl[2]  = '{1'b1, 1'b1, 80, 60, 7, 0};
        tbl[3]  = '{1'b1, 1'b0, 80, 60, 7, 0};
        tbl[4]  = '{1'b1, 1'b0, 80, 60, 7, 0};
        tbl[5]  = '{1'b1, 1'b1, 80, 60, 7, 0};
        tbl[6]  = '{1'b1, 1'b1, 80, 60, 7, 0};
        tbl[7]  = '{1'b1, 1'b1, 80, 60, 0, 0};
        tbl[8]  = '{1'b1, 1'b0, 80, 60, 0, 0};
        tbl[9]  = '{1'b1, 1'b1, 80, 60, 0, 0};
        tbl[10] = '{1'b1, 1'b1, 81, 59, 7, 0};
        for (int i = 0; i < 11; i++) begin
            rs_a = tbl[i].rs;
            st_a = tbl[i].st;
            tick();
            exp_a($sformatf("vec%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].ec, tbl[i].eg);
        end

        // Full trajectory: top wall, right wall, paddle, left wall, top, right, miss.
        st_a = 1'b1;
        px_a = 8'd60;
        steps(59);  exp_a("reach_top", 140, 0, 7, 0);
        steps(1);   exp_a("top_bounce", 141, 1, 7, 0);
        steps(18);  exp_a("reach_right", 159, 19, 7, 0);
        steps(1);   exp_a("right_bounce", 158, 20, 7, 0);
        steps(95);  exp_a("at_paddle", 63, 115, 7, 0);
        steps(1);   exp_a("paddle_bounce", 62, 114, 7, 0);
        steps(62);  exp_a("reach_left", 0, 52, 7, 0);
        steps(1);   exp_a("left_bounce", 1, 51, 7, 0);
        steps(51);  exp_a("top2", 52, 0, 7, 0);
        steps(1);   exp_a("top2_bounce", 53, 1, 7, 0);
        steps(106); exp_a("right2", 159, 107, 7, 0);
        steps(1);   exp_a("right2_bounce", 158, 108, 7, 0);
        steps(7);   exp_a("at_paddle2", 151, 115, 7, 0);
        px_a = 8'd135;  // ballX == paddle_X+16: just outside
        steps(1);   exp_a("miss116", 150, 116, 7, 0);
        steps(1);   exp_a("miss117", 149, 117, 7, 0);
        steps(1);   exp_a("miss118_over", 148, 118, 7, 1);
        st_a = 1'b0;
        steps(3);   exp_a("over_frozen", 148, 118, 7, 1);
        st_a = 1'b1;
        rs_a = 1'b0;
        tick();     exp_a("over_reset", 80, 60, 7, 0);
        rs_a = 1'b1;
        steps(2);   exp_a("reset_idle", 80, 60, 7, 0);

        // Second block: corner hit at x=159 on the paddle row, then no-wrap paddle.
        px_b = 8'd150;
        rs_b = 1'b1;
        st_b = 1'b0;
        tick();
        st_b = 1'b1;
        steps(40);  exp_b("b_top", 44, 0, 7, 0);
        steps(115); exp_b("b_corner_in", 159, 115, 7, 0);
        steps(1);   exp_b("b_corner_bounce", 158, 114, 7, 0);
        rs_b = 1'b0;
        tick();
        rs_b = 1'b1;
        px_b = 8'd255;
        st_b = 1'b0;
        tick();
        st_b = 1'b1;
        steps(155); exp_b("b_nowrap_in", 159, 115, 7, 0);
        steps(1);   exp_b("b_nowrap116", 158, 116, 7, 0);
        steps(2);   exp_b("b_nowrap_over", 156, 118, 7, 1);
        rs_b = 1'b0;

        // Randomized play with paddle mostly tracking the ball, random starts and resets.
        rs_a = 1'b0;
        tick();
        for (int i = 0; i < 15000; i++) begin
            int t;
            if ($urandom_range(0, 3) != 0) begin
                t = ma.x - int'($urandom_range(0, 17));
                if (t < 0) t = 0;
                px_a = 8'(t);
            end else begin
                px_a = 8'($urandom_range(0, 255));
            end
            st_a = ($urandom_range(0, 15) != 0);
            rs_a = ($urandom_range(0, 2999) != 0);
            if (ma.ph == 2 && $urandom_range(0, 49) == 0) rs_a = 1'b0;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
